// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetch PC, PC+4 and instruction word for decode,
// with hazard stall, flush-to-bubble and a saturating valid-instruction counter.
module if_id_reg #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        write_en,
    input  logic        flush,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic [31:0] fetch_count
);

    localparam logic [0:0] BUBBLE = 1'b0;
    localparam logic [0:0] VALID  = 1'b1;

    logic [0:0]  state_q;
    logic        do_flush;
    logic        do_load;
    logic [31:0] pc_plus4;
    logic        count_sat;

    always_comb begin
        do_flush  = flush;
        do_load   = ~flush & write_en;
        pc_plus4  = pc + 32'd4;
        count_sat = (fetch_count == '1);
    end

    // Flush takes priority over the stall: a bubble is inserted even if write_en=0.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= BUBBLE;
            id_pc   <= '0;
            id_pc4  <= '0;
            id_inst <= NOP_WORD;
        end else if (do_flush) begin
            state_q <= BUBBLE;
            id_pc   <= pc;
            id_pc4  <= pc_plus4;
            id_inst <= NOP_WORD;
        end else if (do_load) begin
            state_q <= VALID;
            id_pc   <= pc;
            id_pc4  <= pc_plus4;
            id_inst <= inst;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fetch_count <= '0;
        end else if (do_load && !count_sat) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    always_comb begin
        id_valid = (state_q == VALID);
    end

endmodule

// File: tb/tb_if_id_reg.sv
// Directed self-checking bench for if_id_reg: reset, load, stall, flush, wrap,
// counter saturation and asynchronous reset during a stall.
module tb_if_id_reg;

    logic        clk;
    logic        clrn;
    logic        write_en;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
    logic        id_valid;
    logic [31:0] fetch_count;

    int checks;
    int failures;

    localparam logic [31:0] A    = 32'h2008_0005;
    localparam logic [31:0] B    = 32'h2009_000A;
    localparam logic [31:0] C    = 32'h0109_5020;
    localparam logic [31:0] D    = 32'h8D2A_0004;
    localparam logic [31:0] E    = 32'hAD2A_0008;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    if_id_reg #(.NOP_WORD(32'h0000_0000)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .write_en   (write_en),
        .flush      (flush),
        .pc         (pc),
        .inst       (inst),
        .id_pc      (id_pc),
        .id_pc4     (id_pc4),
        .id_inst    (id_inst),
        .id_valid   (id_valid),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pc4,
                           input logic [31:0] e_inst, input logic e_valid, input logic [31:0] e_cnt);
        chk({tag, ".id_pc"},       id_pc,            e_pc);
        chk({tag, ".id_pc4"},      id_pc4,           e_pc4);
        chk({tag, ".id_inst"},     id_inst,          e_inst);
        chk({tag, ".id_valid"},    {31'd0, id_valid}, {31'd0, e_valid});
        chk({tag, ".fetch_count"}, fetch_count,      e_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clrn     = 1'b1;
        write_en = 1'b1;
        flush    = 1'b0;
        pc       = 32'h40;
        inst     = A;

        // Reset asserted with a load pending: nothing may be captured
        #1 clrn = 1'b0;
        #1;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        tick();
        tick();
        chk_all("reset_hold", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        // Release mid-cycle, then load stream 0/4/8
        @(negedge clk);
        clrn = 1'b1;
        pc = 32'h0; inst = A;
        #1;
        chk_all("post_release", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        tick();
        chk_all("load0", 32'h0, 32'h4, A, 1'b1, 32'd1);
        pc = 32'h4; inst = B;
        tick();
        chk_all("load4", 32'h4, 32'h8, B, 1'b1, 32'd2);
        pc = 32'h8; inst = C;
        tick();
        chk_all("load8", 32'h8, 32'hC, C, 1'b1, 32'd3);

        // Stall three cycles with junk on inst
        write_en = 1'b0; inst = JUNK;
        tick();
        chk_all("stall1", 32'h8, 32'hC, C, 1'b1, 32'd3);
        tick();
        chk_all("stall2", 32'h8, 32'hC, C, 1'b1, 32'd3);
        tick();
        chk_all("stall3", 32'h8, 32'hC, C, 1'b1, 32'd3);

        // Flush with write_en=1, then consecutive flush with write_en=0
        flush = 1'b1; write_en = 1'b1; pc = 32'h10; inst = JUNK;
        tick();
        chk_all("flush_we1", 32'h10, 32'h14, 32'h0, 1'b0, 32'd3);
        write_en = 1'b0; pc = 32'h14;
        tick();
        chk_all("flush_we0", 32'h14, 32'h18, 32'h0, 1'b0, 32'd3);

        // Load after flush
        flush = 1'b0; write_en = 1'b1; pc = 32'h14; inst = D;
        tick();
        chk_all("load_after_flush", 32'h14, 32'h18, D, 1'b1, 32'd4);

        // pc+4 wraps modulo 2^32; unaligned low bits pass through
        pc = 32'hFFFF_FFFC; inst = E;
        tick();
        chk_all("wrap", 32'hFFFF_FFFC, 32'h0, E, 1'b1, 32'd5);
        pc = 32'h0000_0003; inst = A;
        tick();
        chk_all("unaligned", 32'h3, 32'h7, A, 1'b1, 32'd6);

        // Saturation: preset counter one below max, load twice
        force dut.fetch_count = 32'hFFFF_FFFE;
        #1;
        release dut.fetch_count;
        #1;
        chk("sat_preset", fetch_count, 32'hFFFF_FFFE);
        pc = 32'h20; inst = B;
        tick();
        chk_all("sat1", 32'h20, 32'h24, B, 1'b1, 32'hFFFF_FFFF);
        pc = 32'h24; inst = C;
        tick();
        chk_all("sat2", 32'h24, 32'h28, C, 1'b1, 32'hFFFF_FFFF);

        // Async reset pulsed during a stall, between edges
        write_en = 1'b0; inst = JUNK;
        tick();
        chk_all("pre_async_stall", 32'h24, 32'h28, C, 1'b1, 32'hFFFF_FFFF);
        #1 clrn = 1'b0;
        #1;
        chk_all("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        write_en = 1'b1; pc = 32'h30; inst = D;
        tick();
        chk_all("async_reset_hold", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        tick();
        chk_all("reload", 32'h30, 32'h34, D, 1'b1, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the bench always terminates
    initial begin
        #5000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_reg.md
# if_id_reg

IF/ID pipeline register sitting directly downstream of the program counter. Each cycle it captures the fetched PC, PC+4 and the instruction word returned by instruction memory, and presents them to the decode stage. It supports hazard-unit stalls, branch/jump flushes that insert a bubble, and a valid-instruction counter for performance monitoring.

## Interface
- NOP_WORD, 32'h0000_0000, instruction word driven on a bubble (MIPS sll $0,$0,0)
- clk  in  1  pipeline clock, all state updates on rising edge
- clrn  in  1  asynchronous active-low reset
- write_en  in  1  stage enable from hazard unit; the same signal that enables the PC; 0 = stall (hold contents)
- flush  in  1  kill the instruction currently being fetched (taken branch/jump resolved in ID)
- pc  in  32  current fetch address from the program counter
- inst  in  32  instruction memory read data for pc (combinational read)
- id_pc  out  32  PC of the instruction in ID
- id_pc4  out  32  id_pc + 4
- id_inst  out  32  instruction in ID
- id_valid  out  1  1 = id_inst is a real instruction, 0 = bubble
- fetch_count  out  32  number of valid instructions accepted into ID since reset

## Operation
- Reset (clrn=0, asynchronous, independent of clk): id_pc=0, id_pc4=0, id_inst=NOP_WORD, id_valid=0, fetch_count=0. Held while clrn=0.
- Per rising edge, priority flush > stall > load:
  - flush=1 (regardless of write_en): id_inst<=NOP_WORD, id_valid<=0, id_pc<=pc, id_pc4<=pc+4; fetch_count unchanged.
  - flush=0, write_en=0: all outputs hold; fetch_count unchanged.
  - flush=0, write_en=1: id_pc<=pc, id_pc4<=pc+4, id_inst<=inst, id_valid<=1, fetch_count<=fetch_count+1.
- Two-state view of id_valid: BUBBLE (reset, after flush) and VALID (after load); stall keeps state.
- Arithmetic: pc+4 is modulo 2^32 (pc=32'hFFFF_FFFC gives id_pc4=0); no alignment check, low two bits of pc passed through.
- fetch_count saturates at 32'hFFFF_FFFF; no wrap.
- No combinational path from any input to any output; all outputs are registered.

## Timing
- Latency: one cycle from pc/inst at edge N to id_* visible after edge N.
- Stall: while write_en=0 the program counter also holds, so inst is stable; outputs remain identical across every stalled cycle, any length.
- Flush coincident with write_en=0: flush wins; bubble inserted; the PC decides independently whether to advance.
- Flush for consecutive cycles: a bubble each cycle.
- Reset released mid-cycle: first load happens on the first rising edge with clrn=1 and write_en=1; after reset, id_valid=0 until then.
- clrn asserted during a stall or flush: outputs go to reset values immediately, without waiting for clk.

## Test plan
- Reset: clrn=0 with pc=32'h40, inst=32'h2008_0005, write_en=1 -> id_pc=0, id_inst=0, id_valid=0, fetch_count=0, no change across edges.
- Load stream: release reset, pc=0,4,8 with inst=A,B,C, write_en=1 -> after each edge id_pc/id_inst track with one-cycle latency, id_pc4=pc+4, id_valid=1, fetch_count=1,2,3.
- Stall: after loading pc=8/C, hold write_en=0 for 3 cycles with inst changed to junk -> id_pc=8, id_inst=C, fetch_count=3 for all 3 cycles.
- Flush: flush=1, write_en=1, pc=32'h10 -> id_inst=0, id_valid=0, id_pc=32'h10, fetch_count unchanged; flush=1 with write_en=0 gives the same result.
- Wrap and saturation: pc=32'hFFFF_FFFC load -> id_pc4=0; force fetch_count to 32'hFFFF_FFFE, load twice -> 32'hFFFF_FFFF both times.
- Async reset mid-stall: clrn pulsed low between edges while write_en=0 -> outputs go to reset values before the next edge.
